lc3_isdu_param: RTL and testbench

- Parametrised LC-3 instruction sequencer and control unit, the successor to the fixed-timing control FSM.
- Drives datapath load, gate and mux controls, and SRAM strobes from the current opcode.
- Memory accesses go through one shared read state and one shared write state. A wait counter and an optional ready handshake replace the per-access unrolled states.
- Adds LD, ST, LDI, STI and LEA, JSRR via IR_11, and a build-time option for the pause instruction.

---
 rtl/lc3_ctrl_pkg.sv | 57 +++++
 rtl/lc3_isdu_param_if.sv | 36 +++
 rtl/lc3_isdu_param_mem_timer.sv | 43 ++++
 rtl/lc3_isdu_param.sv | 180 ++++++++++++++++++
 tb/tb_lc3_isdu_param.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_ctrl_pkg.sv
// ============================================================
// Package  : lc3_ctrl_pkg
// Desc     : States, opcodes and mux encodings for lc3_isdu_param
// Revision : 1.0
// ============================================================
`default_nettype none

package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED = 5'd0,
        S_FETCH, S_MEM_RD, S_MEM_WR, S_IR_LD, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_T, S_JMP, S_JSR, S_JSR_T, S_LEA,
        S_LD, S_LDI, S_LDR, S_ST, S_STI, S_STR, S_IND, S_IND_S,
        S_WB, S_SDATA, S_PAUSE1, S_PAUSE2
    } state_e;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_STI   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       mem_oe_n, mem_we_n;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/lc3_isdu_param_if.sv
// ============================================================
// Interface : lc3_isdu_param_if
// Desc      : Control-unit inputs and datapath/SRAM control outputs
// Revision  : 1.0
// ============================================================
`default_nettype none

interface lc3_isdu_param_if;
    logic       Run, Continue;
    logic [3:0] Opcode;
    logic       IR_5, IR_11, BEN, Mem_Ready;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       Mem_CE_N, Mem_UB_N, Mem_LB_N, Mem_OE_N, Mem_WE_N;
    logic       Busy;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output DRMUX, SR1MUX, SR2MUX, ADDR1MUX, PCMUX, ADDR2MUX, ALUK,
        output Mem_CE_N, Mem_UB_N, Mem_LB_N, Mem_OE_N, Mem_WE_N, Busy
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, PCMUX, ADDR2MUX, ALUK,
        input  Mem_CE_N, Mem_UB_N, Mem_LB_N, Mem_OE_N, Mem_WE_N, Busy
    );
endinterface

`default_nettype wire

// File: rtl/lc3_isdu_param_mem_timer.sv
// ============================================================
// Module   : lc3_mem_timer
// Desc     : Memory access cycle counter with optional ready qualification
// Revision : 1.0
// ============================================================
`default_nettype none

module lc3_mem_timer #(
    parameter int MEM_CYCLES = 3,
    parameter int USE_READY  = 0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic start,
    input  wire logic active,
    input  wire logic mem_ready,
    output logic      done
);
    localparam int             CW   = $clog2(MEM_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(MEM_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;
    logic          at_last;

    assign at_last = (count_q == LAST);
    // At the terminal count the counter simply holds until ready arrives.
    assign done    = active && at_last && (mem_ready || (USE_READY == 0));

    always_comb begin
        count_d = count_q;
        if (start || done)
            count_d = '0;
        else if (active && !at_last)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

`default_nettype wire

// File: rtl/lc3_isdu_param.sv
// ============================================================
// Module   : lc3_isdu_param
// Desc     : LC-3 sequencer with shared, parametrised memory states
// Revision : 1.0
// ============================================================
`default_nettype none

module lc3_isdu_param
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_CYCLES   = 3,
    parameter int USE_READY    = 0,
    parameter int ENABLE_PAUSE = 1
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    lc3_isdu_param_if.master  bus
);
    state_e state_q, state_d, ret_q, ret_d;
    ctrl_t  c;
    logic   mem_active, mem_start, mem_done;

    assign mem_active = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign mem_start  = !mem_active && ((state_d == S_MEM_RD) || (state_d == S_MEM_WR));

    lc3_mem_timer #(.MEM_CYCLES(MEM_CYCLES), .USE_READY(USE_READY)) u_mem_timer (
        .clk(Clk), .rst(Reset), .start(mem_start), .active(mem_active),
        .mem_ready(bus.Mem_Ready), .done(mem_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_HALTED;
            ret_q   <= S_HALTED;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        c          = '0;
        c.mem_oe_n = 1'b1;
        c.mem_we_n = 1'b1;
        case (state_q)
            S_HALTED: if (bus.Run) state_d = S_FETCH;
            S_FETCH: begin
                c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = PCMUX_PC1;
                ret_d = S_IR_LD; state_d = S_MEM_RD;
            end
            S_MEM_RD: begin
                c.mem_oe_n = 1'b0; c.ld_mdr = 1'b1;
                if (mem_done) state_d = ret_q;
            end
            S_MEM_WR: begin
                c.mem_we_n = 1'b0;
                if (mem_done) state_d = S_FETCH;
            end
            S_IR_LD: begin
                c.gate_mdr = 1'b1; c.ld_ir = 1'b1; state_d = S_DECODE;
            end
            S_DECODE: begin
                c.ld_ben = 1'b1;
                case (bus.Opcode)
                    OP_BR:    state_d = S_BR;
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_JMP:   state_d = S_JMP;
                    OP_JSR:   state_d = S_JSR;
                    OP_LEA:   state_d = S_LEA;
                    OP_LD:    state_d = S_LD;
                    OP_LDI:   state_d = S_LDI;
                    OP_LDR:   state_d = S_LDR;
                    OP_ST:    state_d = S_ST;
                    OP_STI:   state_d = S_STI;
                    OP_STR:   state_d = S_STR;
                    OP_PAUSE: state_d = (ENABLE_PAUSE != 0) ? S_PAUSE1 : S_FETCH;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                if (state_q == S_NOT) begin
                    c.sr1mux = 1'b1; c.aluk = ALUK_NOT;
                end else begin
                    c.sr2mux = bus.IR_5;
                    c.aluk   = (state_q == S_ADD) ? ALUK_ADD : ALUK_AND;
                end
                state_d = S_FETCH;
            end
            S_BR: state_d = bus.BEN ? S_BR_T : S_FETCH;
            S_BR_T: begin
                c.addr2mux = ADDR2_OFF9; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
                state_d = S_FETCH;
            end
            S_JMP: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = ADDR2_ZERO;
                c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1; state_d = S_FETCH;
            end
            S_JSR: begin
                c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; state_d = S_JSR_T;
            end
            S_JSR_T: begin
                if (bus.IR_11) begin
                    c.addr2mux = ADDR2_OFF11;
                end else begin
                    c.addr1mux = 1'b1; c.sr1mux = 1'b1; c.addr2mux = ADDR2_ZERO;
                end
                c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1; state_d = S_FETCH;
            end
            S_LEA: begin
                c.addr2mux = ADDR2_OFF9; c.gate_marmux = 1'b1;
                c.ld_reg = 1'b1; c.ld_cc = 1'b1; state_d = S_FETCH;
            end
            S_LD, S_LDI, S_ST, S_STI, S_LDR, S_STR: begin
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
                if (state_q == S_LDR || state_q == S_STR) begin
                    c.addr1mux = 1'b1; c.sr1mux = 1'b1; c.addr2mux = ADDR2_OFF6;
                end else begin
                    c.addr2mux = ADDR2_OFF9;
                end
                case (state_q)
                    S_LD, S_LDR: begin state_d = S_MEM_RD; ret_d = S_WB;    end
                    S_LDI:       begin state_d = S_MEM_RD; ret_d = S_IND;   end
                    S_STI:       begin state_d = S_MEM_RD; ret_d = S_IND_S; end
                    default:     state_d = S_SDATA;
                endcase
            end
            S_IND: begin
                c.gate_mdr = 1'b1; c.ld_mar = 1'b1; ret_d = S_WB; state_d = S_MEM_RD;
            end
            S_IND_S: begin
                c.gate_mdr = 1'b1; c.ld_mar = 1'b1; state_d = S_SDATA;
            end
            S_WB: begin
                c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; state_d = S_FETCH;
            end
            S_SDATA: begin
                c.aluk = ALUK_PASSA; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; state_d = S_MEM_WR;
            end
            S_PAUSE1: begin
                c.ld_led = 1'b1;
                if (bus.Continue) state_d = S_PAUSE2;
            end
            S_PAUSE2: if (!bus.Continue) state_d = S_FETCH;
            default:  state_d = S_HALTED;
        endcase
    end

    assign bus.LD_MAR     = c.ld_mar;
    assign bus.LD_MDR     = c.ld_mdr;
    assign bus.LD_IR      = c.ld_ir;
    assign bus.LD_BEN     = c.ld_ben;
    assign bus.LD_CC      = c.ld_cc;
    assign bus.LD_REG     = c.ld_reg;
    assign bus.LD_PC      = c.ld_pc;
    assign bus.LD_LED     = c.ld_led;
    assign bus.GatePC     = c.gate_pc;
    assign bus.GateMDR    = c.gate_mdr;
    assign bus.GateALU    = c.gate_alu;
    assign bus.GateMARMUX = c.gate_marmux;
    assign bus.DRMUX      = c.drmux;
    assign bus.SR1MUX     = c.sr1mux;
    assign bus.SR2MUX     = c.sr2mux;
    assign bus.ADDR1MUX   = c.addr1mux;
    assign bus.PCMUX      = c.pcmux;
    assign bus.ADDR2MUX   = c.addr2mux;
    assign bus.ALUK       = c.aluk;
    assign bus.Mem_OE_N   = c.mem_oe_n;
    assign bus.Mem_WE_N   = c.mem_we_n;
    assign bus.Mem_CE_N   = 1'b0;
    assign bus.Mem_UB_N   = 1'b0;
    assign bus.Mem_LB_N   = 1'b0;
    assign bus.Busy       = (state_q != S_HALTED);
endmodule

`default_nettype wire

// File: tb/tb_lc3_isdu_param.sv
// ============================================================
// Module   : tb_lc3_isdu_param
// Desc     : Scoreboard bench for two lc3_isdu_param configurations
// Revision : 1.0
// ============================================================
`default_nettype none

module tb_lc3_isdu_param;
    typedef struct packed {
        logic       busy;
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       ce_n, ub_n, lb_n, oe_n, we_n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_v = 1'b0, cont_v = 1'b0, rdy_v = 1'b0;
    logic       ir5 = 1'b0, ir11 = 1'b0, ben = 1'b0;
    logic [3:0] opc = 4'd0;
    logic       sel = 1'b0;
    int         checks = 0, errors = 0, next_w = -1;
    exp_t       sb_q[$];
    string      tag_q[$];
    exp_t       act0, act1, m_e, m_a, m_o;
    string      m_t;

    always #5 clk = ~clk;

    lc3_isdu_param_if if0 ();
    lc3_isdu_param_if if1 ();

    assign if0.Run = run_v & ~sel;   assign if1.Run = run_v & sel;
    assign if0.Continue = cont_v;    assign if1.Continue = cont_v;
    assign if0.Opcode = opc;         assign if1.Opcode = opc;
    assign if0.IR_5 = ir5;           assign if1.IR_5 = ir5;
    assign if0.IR_11 = ir11;         assign if1.IR_11 = ir11;
    assign if0.BEN = ben;            assign if1.BEN = ben;
    assign if0.Mem_Ready = rdy_v;    assign if1.Mem_Ready = rdy_v;

    lc3_isdu_param #(.MEM_CYCLES(3), .USE_READY(0), .ENABLE_PAUSE(1)) dut0 (
        .Clk(clk), .Reset(rst), .bus(if0));
    lc3_isdu_param #(.MEM_CYCLES(1), .USE_READY(1), .ENABLE_PAUSE(0)) dut1 (
        .Clk(clk), .Reset(rst), .bus(if1));

    assign act0 = {if0.Busy, if0.LD_MAR, if0.LD_MDR, if0.LD_IR, if0.LD_BEN, if0.LD_CC,
                   if0.LD_REG, if0.LD_PC, if0.LD_LED, if0.GatePC, if0.GateMDR, if0.GateALU,
                   if0.GateMARMUX, if0.DRMUX, if0.SR1MUX, if0.SR2MUX, if0.ADDR1MUX, if0.PCMUX,
                   if0.ADDR2MUX, if0.ALUK, if0.Mem_CE_N, if0.Mem_UB_N, if0.Mem_LB_N,
                   if0.Mem_OE_N, if0.Mem_WE_N};
    assign act1 = {if1.Busy, if1.LD_MAR, if1.LD_MDR, if1.LD_IR, if1.LD_BEN, if1.LD_CC,
                   if1.LD_REG, if1.LD_PC, if1.LD_LED, if1.GatePC, if1.GateMDR, if1.GateALU,
                   if1.GateMARMUX, if1.DRMUX, if1.SR1MUX, if1.SR2MUX, if1.ADDR1MUX, if1.PCMUX,
                   if1.ADDR2MUX, if1.ALUK, if1.Mem_CE_N, if1.Mem_UB_N, if1.Mem_LB_N,
                   if1.Mem_OE_N, if1.Mem_WE_N};

    function automatic exp_t idle();
        exp_t e;
        e = '0; e.oe_n = 1'b1; e.we_n = 1'b1;
        return e;
    endfunction

    function automatic exp_t act();
        exp_t e;
        e = idle(); e.busy = 1'b1;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int mc();
        return sel ? 1 : 3;
    endfunction

    // Monitor: every cycle with a pending expectation is compared, and the
    // instance that is not under test must sit idle in HALTED.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            m_t = tag_q.pop_front();
            m_a = sel ? act1 : act0;
            m_o = sel ? act0 : act1;
            checks++;
            if (m_a !== m_e) begin
                errors++;
                $display("FAIL %s @%0t sel=%0d: got=%07h exp=%07h", m_t, $time, sel, m_a, m_e);
            end
            checks++;
            if (m_o !== idle()) begin
                errors++;
                $display("FAIL idle_inst @%0t sel=%0d: got=%07h exp=%07h", $time, sel, m_o, idle());
            end
        end
    end

    task automatic cyc(input exp_t e, input string tag, input logic rdy, input logic cont,
                       input logic run, input logic rs);
        rdy_v = rdy; cont_v = cont; run_v = run; rst = rs;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    task automatic c1(input exp_t e, input string tag);
        cyc(e, tag, rb(), rb(), rb(), 1'b0);
    endtask

    // One memory window: MEM_CYCLES cycles, stretched by w cycles of late
    // ready when the instance waits for Mem_Ready.
    task automatic rw(input logic wr);
        int   w, n;
        exp_t e;
        logic r;
        w = 0;
        if (sel) begin
            w = (next_w >= 0) ? next_w : int'($urandom_range(0, 4));
            next_w = -1;
        end
        n = mc() + w;
        for (int i = 0; i < n; i++) begin
            e = act();
            if (wr) e.we_n = 1'b0;
            else begin e.oe_n = 1'b0; e.ld_mdr = 1'b1; end
            if (sel) r = (i == n - 1) ? 1'b1 : ((i < mc() - 1) ? rb() : 1'b0);
            else     r = rb();
            cyc(e, wr ? "mem_wr" : "mem_rd", r, rb(), rb(), 1'b0);
        end
    endtask

    function automatic exp_t fetch_vec();
        exp_t e;
        e = act(); e.gate_pc = 1'b1; e.ld_mar = 1'b1; e.ld_pc = 1'b1;
        return e;
    endfunction

    task automatic fetch();
        exp_t e;
        c1(fetch_vec(), "fetch");
        rw(1'b0);
        e = act(); e.gate_mdr = 1'b1; e.ld_ir = 1'b1; c1(e, "ir_ld");
        e = act(); e.ld_ben = 1'b1; c1(e, "decode");
    endtask

    task automatic exec(input logic [3:0] op);
        exp_t e;
        int   k;
        e = act();
        case (op)
            4'b0000: begin
                c1(e, "br");
                if (ben) begin
                    e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1'b1; c1(e, "br_t");
                end
            end
            4'b0001, 4'b0101, 4'b1001: begin
                e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
                if (op == 4'b1001) begin e.sr1mux = 1'b1; e.aluk = 2'b10; end
                else begin e.sr2mux = ir5; e.aluk = (op == 4'b0101) ? 2'b01 : 2'b00; end
                c1(e, "alu");
            end
            4'b1100: begin
                e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.pcmux = 2'b10; e.ld_pc = 1'b1;
                c1(e, "jmp");
            end
            4'b0100: begin
                e.gate_pc = 1'b1; e.drmux = 1'b1; e.ld_reg = 1'b1; c1(e, "jsr");
                e = act(); e.pcmux = 2'b10; e.ld_pc = 1'b1;
                if (ir11) e.addr2mux = 2'b11;
                else begin e.addr1mux = 1'b1; e.sr1mux = 1'b1; end
                c1(e, "jsr_t");
            end
            4'b1110: begin
                e.addr2mux = 2'b10; e.gate_marmux = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
                c1(e, "lea");
            end
            4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1010, 4'b1011: begin
                // op[3] marks the indirect forms, op[0] the stores
                e.gate_marmux = 1'b1; e.ld_mar = 1'b1;
                if (op == 4'b0110 || op == 4'b0111) begin
                    e.addr1mux = 1'b1; e.sr1mux = 1'b1; e.addr2mux = 2'b01;
                end else e.addr2mux = 2'b10;
                c1(e, "addr");
                if (op[3]) begin
                    rw(1'b0);
                    e = act(); e.gate_mdr = 1'b1; e.ld_mar = 1'b1; c1(e, "ind");
                end
                if (op[0]) begin
                    e = act(); e.aluk = 2'b11; e.gate_alu = 1'b1; e.ld_mdr = 1'b1; c1(e, "sdata");
                    rw(1'b1);
                end else begin
                    rw(1'b0);
                    e = act(); e.gate_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1; c1(e, "wb");
                end
            end
            4'b1101: if (!sel) begin
                e.ld_led = 1'b1;
                k = int'($urandom_range(0, 3));
                for (int i = 0; i < k; i++) cyc(e, "pause1", rb(), 1'b0, rb(), 1'b0);
                cyc(e, "pause1", rb(), 1'b1, rb(), 1'b0);
                e = act();
                k = int'($urandom_range(0, 3));
                for (int i = 0; i < k; i++) cyc(e, "pause2", rb(), 1'b1, rb(), 1'b0);
                cyc(e, "pause2", rb(), 1'b0, rb(), 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic instr(input logic [3:0] op, input logic b5, input logic b11, input logic bb);
        opc = op; ir5 = b5; ir11 = b11; ben = bb;
        fetch();
        exec(op);
    endtask

    task automatic start_phase(input logic s);
        rst = 1'b1; run_v = 1'b0; sel = s;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc(idle(), "reset_state", rb(), rb(), 1'b0, 1'b0);
        cyc(idle(), "halted_run", rb(), rb(), 1'b1, 1'b0);
    endtask

    initial begin
        exp_t e;
        // Configuration 0: three-cycle accesses, ready ignored, pause enabled
        start_phase(1'b0);
        instr(4'b1010, rb(), rb(), rb());
        instr(4'b1011, rb(), rb(), rb());
        instr(4'b0000, rb(), rb(), 1'b0);
        instr(4'b0000, rb(), rb(), 1'b1);
        instr(4'b0100, rb(), 1'b0, rb());
        instr(4'b0100, rb(), 1'b1, rb());
        instr(4'b1101, rb(), rb(), rb());
        // Reset lands in the second cycle of the fetch read
        opc = 4'b0001;
        c1(fetch_vec(), "fetch");
        e = act(); e.oe_n = 1'b0; e.ld_mdr = 1'b1;
        c1(e, "mem_rd");
        cyc(e, "mem_rd_rst", rb(), rb(), 1'b1, 1'b1);
        cyc(idle(), "after_rst", rb(), rb(), 1'b0, 1'b0);
        cyc(idle(), "halted_run", rb(), rb(), 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) instr(4'($urandom_range(0, 15)), rb(), rb(), rb());

        // Configuration 1: single-cycle accesses gated by Mem_Ready, no pause
        start_phase(1'b1);
        next_w = 5;
        instr(4'b1101, rb(), rb(), rb());
        for (int i = 0; i < 40; i++) instr(4'($urandom_range(0, 15)), rb(), rb(), rb());

        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d pending exp=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
